axi_lite_pattern_master: RTL and testbench

//  Parametrised AXI4-Lite master pattern generator/checker. It is the next generation of the controller_AXI bring-up master.
//  On an INIT pulse it writes N words of a deterministic pattern to a slave region, then optionally reads them back and compares.

---
 rtl/axi_lite_pattern_pkg.sv | 15 +
 rtl/axi_lite_pattern_gen.sv | 42 ++++
 rtl/axi_lite_pattern_master.sv | 209 ++++++++++++++++++++
 tb/tb_axi_lite_pattern_master.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pattern_pkg.sv
// Shared types and constants for the AXI4-Lite pattern master.
package axi_lite_pattern_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  typedef enum logic [1:0] {PH_ISSUE, PH_ADDR, PH_RESP} phase_t;

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_WRC = 2'd0;
  localparam mode_t MODE_WO  = 2'd1;
  localparam mode_t MODE_RC  = 2'd2;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int unsigned IDX_W = 16;

endpackage

// File: rtl/axi_lite_pattern_gen.sv
// Beat index counter with address / expected-data generation, shared by the write and read paths.
module axi_lite_pattern_gen
  import axi_lite_pattern_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned NUM_TXN = 16,
  parameter logic [AW-1:0] BASE  = 32'h4000_0000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_rewind,
  input  logic          i_advance,
  input  logic [DW-1:0] i_seed,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_last
);

  logic [IDX_W-1:0] r_index;
  logic [DW-1:0]    r_seed;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_index <= '0;
      r_seed  <= '0;
    end else if (i_start) begin
      r_index <= '0;
      r_seed  <= i_seed;
    end else if (i_rewind) begin
      r_index <= '0;
    end else if (i_advance) begin
      r_index <= r_index + IDX_W'(1);
    end
  end

  assign o_addr = BASE + AW'(r_index) * AW'(DW / 8);
  assign o_data = r_seed + DW'(r_index);
  assign o_last = (r_index == IDX_W'(NUM_TXN - 1));

endmodule

// File: rtl/axi_lite_pattern_master.sv
// AXI4-Lite master that writes a seed+index pattern to a slave region, reads it back and counts
// failing beats. Each beat runs issue / address-handshake / response phases, one outstanding.
module axi_lite_pattern_master
  import axi_lite_pattern_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE_ADDR = 32'h4000_0000,
  parameter int unsigned C_NUM_TXN = 16,
  parameter int unsigned C_ERR_CNT_WIDTH = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            INIT_AXI_TXN,
  input  logic [1:0]                      MODE,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   SEED,
  output logic                            TXN_DONE,
  output logic                            BUSY,
  output logic                            ERROR,
  output logic [C_ERR_CNT_WIDTH-1:0]      ERR_COUNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   FIRST_ERR_ADDR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;

  state_t               r_state;
  phase_t               r_phase;
  mode_t                r_mode;
  logic                 r_init_q;
  logic                 r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [AW-1:0]        r_addr;
  logic [DW-1:0]        r_wdata;
  logic                 r_done, r_busy, r_error;
  logic [C_ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [AW-1:0]        r_first_addr;

  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          w_last, w_start, w_b_hs, w_r_hs, w_beat_done, w_fail;

  assign w_start = INIT_AXI_TXN & ~r_init_q & ((r_state == IDLE) | (r_state == DONE));
  assign w_b_hs  = M_AXI_BVALID & r_bready;
  assign w_r_hs  = M_AXI_RVALID & r_rready;
  assign w_beat_done = ((r_state == WRITE) & w_b_hs) | ((r_state == READ) & w_r_hs);
  assign w_fail  = ((r_state == WRITE) & w_b_hs & (M_AXI_BRESP != RESP_OKAY)) |
                   ((r_state == READ) & w_r_hs &
                    ((M_AXI_RRESP != RESP_OKAY) | (M_AXI_RDATA != w_data)));

  axi_lite_pattern_gen #(
    .AW      (AW),
    .DW      (DW),
    .NUM_TXN (C_NUM_TXN),
    .BASE    (C_TARGET_BASE_ADDR)
  ) u_gen (
    .i_clk     (ACLK),
    .i_rst     (ARESET),
    .i_start   (w_start),
    .i_rewind  ((r_state == WRITE) & w_b_hs & w_last),
    .i_advance (w_beat_done & ~w_last),
    .i_seed    (SEED),
    .o_addr    (w_addr),
    .o_data    (w_data),
    .o_last    (w_last)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= IDLE;
      r_phase      <= PH_ISSUE;
      r_mode       <= MODE_WRC;
      r_init_q     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_err_cnt    <= '0;
      r_first_addr <= '0;
    end else begin
      r_init_q <= INIT_AXI_TXN;
      if (w_fail) begin
        r_error <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + C_ERR_CNT_WIDTH'(1);
        if (!r_error) r_first_addr <= r_addr;
      end
      unique case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_mode       <= MODE;
            r_phase      <= PH_ISSUE;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_error      <= 1'b0;
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_state      <= (MODE == MODE_RC) ? READ : WRITE;
          end
        end
        WRITE: begin
          case (r_phase)
            PH_ISSUE: begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_addr    <= w_addr;
              r_wdata   <= w_data;
              r_phase   <= PH_ADDR;
            end
            PH_ADDR: begin
              // AW and W complete independently, in either order or together
              if (M_AXI_AWREADY) r_awvalid <= 1'b0;
              if (M_AXI_WREADY) r_wvalid <= 1'b0;
              if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY)) begin
                r_bready <= 1'b1;
                r_phase  <= PH_RESP;
              end
            end
            PH_RESP: begin
              if (w_b_hs) begin
                r_bready <= 1'b0;
                r_phase  <= PH_ISSUE;
                if (w_last) begin
                  if (r_mode == MODE_WO) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                  end else begin
                    r_state <= READ;
                  end
                end
              end
            end
            default: r_phase <= PH_ISSUE;
          endcase
        end
        READ: begin
          case (r_phase)
            PH_ISSUE: begin
              r_arvalid <= 1'b1;
              r_addr    <= w_addr;
              r_phase   <= PH_ADDR;
            end
            PH_ADDR: begin
              if (M_AXI_ARREADY) begin
                r_arvalid <= 1'b0;
                r_rready  <= 1'b1;
                r_phase   <= PH_RESP;
              end
            end
            PH_RESP: begin
              if (w_r_hs) begin
                r_rready <= 1'b0;
                r_phase  <= PH_ISSUE;
                if (w_last) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                end
              end
            end
            default: r_phase <= PH_ISSUE;
          endcase
        end
      endcase
    end
  end

  assign TXN_DONE       = r_done;
  assign BUSY           = r_busy;
  assign ERROR          = r_error;
  assign ERR_COUNT      = r_err_cnt;
  assign FIRST_ERR_ADDR = r_first_addr;
  assign M_AXI_AWADDR   = r_addr;
  assign M_AXI_AWPROT   = 3'b000;
  assign M_AXI_AWVALID  = r_awvalid;
  assign M_AXI_WDATA    = r_wdata;
  assign M_AXI_WSTRB    = '1;
  assign M_AXI_WVALID   = r_wvalid;
  assign M_AXI_BREADY   = r_bready;
  assign M_AXI_ARADDR   = r_addr;
  assign M_AXI_ARPROT   = 3'b000;
  assign M_AXI_ARVALID  = r_arvalid;
  assign M_AXI_RREADY   = r_rready;

endmodule

// File: tb/tb_axi_lite_pattern_master.sv
// Randomised bench: memory slave with back-pressure, scoreboard queues fed by a pattern model,
// and a monitor that checks channel traffic, handshake rules and end-of-run results.
module tb_axi_lite_pattern_master;
  import axi_lite_pattern_pkg::*;

  localparam int unsigned NUM = 16;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        ACLK = 1'b0, ARESET = 1'b1, INIT = 1'b0;
  logic [1:0]  MODE = 2'd0;
  logic [31:0] SEED = '0;
  logic        TXN_DONE, BUSY, ERROR;
  logic [15:0] ERR_COUNT;
  logic [31:0] FIRST_ERR_ADDR, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  axi_lite_pattern_master #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_TARGET_BASE_ADDR (BASE),
    .C_NUM_TXN          (NUM),
    .C_ERR_CNT_WIDTH    (16)
  ) dut (
    .ACLK (ACLK), .ARESET (ARESET), .INIT_AXI_TXN (INIT), .MODE (MODE), .SEED (SEED),
    .TXN_DONE (TXN_DONE), .BUSY (BUSY), .ERROR (ERROR), .ERR_COUNT (ERR_COUNT),
    .FIRST_ERR_ADDR (FIRST_ERR_ADDR),
    .M_AXI_AWADDR (M_AXI_AWADDR), .M_AXI_AWPROT (M_AXI_AWPROT), .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (s_awready), .M_AXI_WDATA (M_AXI_WDATA), .M_AXI_WSTRB (M_AXI_WSTRB),
    .M_AXI_WVALID (M_AXI_WVALID), .M_AXI_WREADY (s_wready), .M_AXI_BRESP (s_bresp),
    .M_AXI_BVALID (s_bvalid), .M_AXI_BREADY (M_AXI_BREADY),
    .M_AXI_ARADDR (M_AXI_ARADDR), .M_AXI_ARPROT (M_AXI_ARPROT), .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (s_arready), .M_AXI_RDATA (s_rdata), .M_AXI_RRESP (s_rresp),
    .M_AXI_RVALID (s_rvalid), .M_AXI_RREADY (M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0, n_pass = 0, viol = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: unexpected beat 0x%0h, nothing expected", name, act);
  endtask

  // ---------------- memory slave ----------------
  logic [31:0]    mem [NUM];
  logic [31:0]    ref_mem [NUM];
  bit             bp;
  logic [NUM-1:0] berr_mask = '0, rerr_mask = '0;
  bit             sl_aw_got, sl_w_got, sl_ar_got;
  int             sl_aw_idx, sl_ar_idx;
  logic [31:0]    sl_wdata;

  function automatic int idx_of(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % NUM);
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      s_awready <= 1'b0; s_wready <= 1'b0; s_arready <= 1'b0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0; s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
      sl_aw_got = 0; sl_w_got = 0; sl_ar_got = 0;
    end else begin
      if (M_AXI_AWVALID && s_awready) begin sl_aw_got = 1; sl_aw_idx = idx_of(M_AXI_AWADDR); end
      if (M_AXI_WVALID && s_wready) begin sl_w_got = 1; sl_wdata = M_AXI_WDATA; end
      if (s_bvalid && M_AXI_BREADY) s_bvalid <= 1'b0;
      else if (!s_bvalid && sl_aw_got && sl_w_got && (!bp || $urandom_range(0, 2) == 0)) begin
        mem[sl_aw_idx] = sl_wdata;
        s_bvalid <= 1'b1;
        s_bresp  <= berr_mask[sl_aw_idx] ? 2'b10 : 2'b00;
        sl_aw_got = 0; sl_w_got = 0;
      end
      if (M_AXI_ARVALID && s_arready) begin sl_ar_got = 1; sl_ar_idx = idx_of(M_AXI_ARADDR); end
      if (s_rvalid && M_AXI_RREADY) s_rvalid <= 1'b0;
      else if (!s_rvalid && sl_ar_got && (!bp || $urandom_range(0, 2) == 0)) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[sl_ar_idx];
        s_rresp  <= rerr_mask[sl_ar_idx] ? 2'b10 : 2'b00;
        sl_ar_got = 0;
      end
      s_awready <= bp ? ($urandom_range(0, 2) == 0) : 1'b1;
      s_wready  <= bp ? ($urandom_range(0, 2) == 0) : 1'b1;
      s_arready <= bp ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int unsigned cnt;
    logic        err;
    logic [31:0] first;
  } res_t;

  logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
  res_t        exp_res[$];

  task automatic flush();
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_res.delete();
  endtask

  function automatic void note_fail(inout res_t r, input logic [31:0] addr);
    if (!r.err) r.first = addr;
    r.err = 1'b1;
    r.cnt++;
  endfunction

  // Reference model: the whole run's traffic and outcome from the pattern rules.
  task automatic expect_run(input logic [1:0] m, input logic [31:0] seed,
                            input logic [NUM-1:0] be, input logic [NUM-1:0] re);
    res_t r;
    r = '{cnt: 0, err: 1'b0, first: '0};
    if (m != MODE_RC)
      for (int i = 0; i < NUM; i++) begin
        exp_aw.push_back(BASE + 32'(i) * 4);
        exp_w.push_back(seed + 32'(i));
        ref_mem[i] = seed + 32'(i);
        if (be[i]) note_fail(r, BASE + 32'(i) * 4);
      end
    if (m != MODE_WO)
      for (int i = 0; i < NUM; i++) begin
        exp_ar.push_back(BASE + 32'(i) * 4);
        if (re[i] || ref_mem[i] != seed + 32'(i)) note_fail(r, BASE + 32'(i) * 4);
      end
    exp_res.push_back(r);
  endtask

  // ---------------- monitor ----------------
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_brdy, p_bv, p_done;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  res_t        got;

  always @(negedge ACLK) begin
    if (ARESET) begin
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_brdy, p_bv, p_done} = '0;
    end else begin
      if (M_AXI_AWVALID && s_awready) begin
        if (exp_aw.size() == 0) unexpected("aw_extra", M_AXI_AWADDR);
        else check("awaddr", M_AXI_AWADDR, exp_aw.pop_front());
        check("awprot", M_AXI_AWPROT, 3'b000);
      end
      if (M_AXI_WVALID && s_wready) begin
        if (exp_w.size() == 0) unexpected("w_extra", M_AXI_WDATA);
        else check("wdata", M_AXI_WDATA, exp_w.pop_front());
        check("wstrb", M_AXI_WSTRB, 4'hF);
      end
      if (M_AXI_ARVALID && s_arready) begin
        if (exp_ar.size() == 0) unexpected("ar_extra", M_AXI_ARADDR);
        else check("araddr", M_AXI_ARADDR, exp_ar.pop_front());
        check("arprot", M_AXI_ARPROT, 3'b000);
      end
      if (TXN_DONE && !p_done) begin
        if (exp_res.size() == 0) unexpected("done_extra", ERR_COUNT);
        else begin
          got = exp_res.pop_front();
          check("err_count", ERR_COUNT, got.cnt);
          check("error", ERROR, got.err);
          check("first_err_addr", FIRST_ERR_ADDR, got.first);
          check("busy_at_done", BUSY, 1'b0);
        end
      end
      if (p_awv && !p_awr && (!M_AXI_AWVALID || M_AXI_AWADDR != p_awaddr)) viol++;
      if (p_wv && !p_wr && (!M_AXI_WVALID || M_AXI_WDATA != p_wdata)) viol++;
      if (p_arv && !p_arr && (!M_AXI_ARVALID || M_AXI_ARADDR != p_araddr)) viol++;
      if (M_AXI_AWVALID && !p_awv && !(M_AXI_WVALID && !p_wv)) viol++;
      if (p_brdy && !p_bv && !M_AXI_BREADY) viol++;
      if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) viol++;
      if (M_AXI_RREADY && M_AXI_ARVALID) viol++;
      if ((M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY) && (M_AXI_ARVALID || M_AXI_RREADY))
        viol++;
      p_awv = M_AXI_AWVALID; p_awr = s_awready; p_awaddr = M_AXI_AWADDR;
      p_wv = M_AXI_WVALID; p_wr = s_wready; p_wdata = M_AXI_WDATA;
      p_arv = M_AXI_ARVALID; p_arr = s_arready; p_araddr = M_AXI_ARADDR;
      p_brdy = M_AXI_BREADY; p_bv = s_bvalid; p_done = TXN_DONE;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input string tag, input logic [1:0] m, input logic [31:0] seed,
                     input logic [NUM-1:0] be, input logic [NUM-1:0] re, input bit bpr,
                     input int glitch);
    int n, passes;
    logic busy_seen;
    flush();
    expect_run(m, seed, be, re);
    berr_mask = be; rerr_mask = re; bp = bpr; viol = 0;
    @(negedge ACLK);
    MODE = m; SEED = seed; INIT = 1'b1;
    n = 0;
    busy_seen = 1'b0;
    do begin
      @(posedge ACLK); n++;
      @(negedge ACLK);
      if (n == 1) begin INIT = 1'b0; busy_seen = BUSY; end
      if (n == glitch) INIT = 1'b1;
      if (n == glitch + 1) INIT = 1'b0;
    end while (!TXN_DONE && n < 4000);
    @(negedge ACLK);
    passes = (m == MODE_WO || m == MODE_RC) ? 1 : 2;
    check({tag, "_done"}, TXN_DONE, 1'b1);
    check({tag, "_busy_next_cycle"}, busy_seen, 1'b1);
    if (!bpr) check({tag, "_latency"}, n, 3 * NUM * passes + 1);
    check({tag, "_aw_left"}, exp_aw.size(), 0);
    check({tag, "_ar_left"}, exp_ar.size(), 0);
    check({tag, "_res_left"}, exp_res.size(), 0);
    check({tag, "_protocol"}, viol, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < NUM; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(negedge ACLK);
    check("rst_awvalid", M_AXI_AWVALID, 1'b0);
    check("rst_wvalid", M_AXI_WVALID, 1'b0);
    check("rst_bready", M_AXI_BREADY, 1'b0);
    check("rst_arvalid", M_AXI_ARVALID, 1'b0);
    check("rst_rready", M_AXI_RREADY, 1'b0);
    check("rst_done", TXN_DONE, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_error", ERROR, 1'b0);
    check("rst_err_count", ERR_COUNT, 16'd0);
    check("rst_first", FIRST_ERR_ADDR, 32'd0);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);

    run("wrc", MODE_WRC, 32'h0000_1000, '0, '0, 1'b0, -10);
    mem[5] ^= 32'h0000_0100;
    ref_mem[5] ^= 32'h0000_0100;
    run("rc_corrupt", MODE_RC, 32'h0000_1000, '0, '0, 1'b0, -10);
    run("wo_slverr", MODE_WO, 32'h0000_2000, 16'h0088, '0, 1'b0, -10);
    run("wrc_bp", MODE_WRC, 32'h0000_3000, '0, '0, 1'b1, -10);
    run("init_busy", MODE_WRC, 32'h0000_4000, '0, '0, 1'b0, 20);

    // Reset in the middle of the write phase, with an error already recorded.
    flush();
    expect_run(MODE_WRC, 32'hA5A5_0000, 16'h0002, '0);
    berr_mask = 16'h0002; rerr_mask = '0; bp = 1'b0;
    @(negedge ACLK);
    MODE = MODE_WRC; SEED = 32'hA5A5_0000; INIT = 1'b1;
    @(negedge ACLK);
    INIT = 1'b0;
    n = 0;
    while (!(M_AXI_AWVALID && M_AXI_AWADDR == BASE + 32'h14) && n < 400) begin
      @(negedge ACLK); n++;
    end
    check("reach_beat5", M_AXI_AWVALID, 1'b1);
    check("err_before_rst", ERR_COUNT, 16'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("mid_rst_awvalid", M_AXI_AWVALID, 1'b0);
    check("mid_rst_wvalid", M_AXI_WVALID, 1'b0);
    check("mid_rst_bready", M_AXI_BREADY, 1'b0);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_error", ERROR, 1'b0);
    check("mid_rst_err_count", ERR_COUNT, 16'd0);
    check("mid_rst_first", FIRST_ERR_ADDR, 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    flush();
    berr_mask = '0;
    run("after_rst", MODE_WRC, 32'h0000_5000, '0, '0, 1'b0, -10);
    run("wrap", MODE_WRC, 32'hFFFF_FFFE, '0, '0, 1'b0, -10);

    for (int k = 0; k < 8; k++) begin
      logic [1:0]  m;
      logic [31:0] s;
      logic [15:0] be, re;
      m  = 2'($urandom_range(0, 3));
      s  = $urandom;
      be = 16'($urandom & $urandom & $urandom);
      re = 16'($urandom & $urandom & $urandom);
      run($sformatf("rand%0d", k), m, s, be, re, 1'b1, -10);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
